dds_cmd_ctrl: RTL and testbench
===============================

DDS_CMD_CTRL -- requirements
Module: dds_cmd_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 100000, giving the maximum gap in clk cycles between bytes of one frame (1 ms at 100 MHz).
REQ-002 The block SHALL have parameter HDR, default 8'hAA, giving the frame header byte.
REQ-003 The block SHALL have port clk, input, 1 bit: single system clock, all logic on rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port rx_data, input, 8 bits: received byte, valid when rx_dong_sig=1.
REQ-006 The block SHALL have port rx_dong_sig, input, 1 bit: one-cycle byte-valid strobe from the UART receiver.
REQ-007 The block SHALL have port freq_word, output, 32 bits: DDS frequency tuning word.
REQ-008 The block SHALL have port phase_word, output, 12 bits: DDS phase offset.
REQ-009 The block SHALL have port wave_sel, output, 2 bits: waveform select (0 sine, 1 triangle, 2 square, 3 sawtooth).
REQ-010 The block SHALL have port cfg_update, output, 1 bit: one-cycle pulse when any config register changes.
REQ-011 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse on checksum error, unknown command or timeout.

Function
REQ-012 Frame format SHALL be: HDR, CMD, D0..D3 (D0 MSB), CHK, with CHK = CMD^D0^D1^D2^D3.
REQ-013 FSM states SHALL be IDLE, CMD, DATA, CHK, and a byte SHALL be consumed only in a cycle with rx_dong_sig=1.
REQ-014 In IDLE, a byte equal to HDR SHALL go to CMD, and any other byte SHALL be ignored (stay IDLE, no error).
REQ-015 In CMD, a byte SHALL be latched as the command, the XOR accumulator SHALL be initialised to that byte, and the FSM SHALL go to DATA with byte counter 0.
REQ-016 In DATA, each byte SHALL be shifted into a 32-bit shift register (left shift, new byte in LSBs) and XORed into the accumulator; after the 4th byte (counter 3) the FSM SHALL go to CHK.
REQ-017 A byte equal to HDR received in CMD/DATA/CHK SHALL be treated as ordinary payload, with no resynchronisation.
REQ-018 In CHK, if the byte equals the accumulator and CMD=8'h01, freq_word SHALL be loaded with the 32-bit shift register.
REQ-019 In CHK, if the byte equals the accumulator and CMD=8'h02, phase_word SHALL be loaded with shift register bits [11:0].
REQ-020 In CHK, if the byte equals the accumulator and CMD=8'h03, wave_sel SHALL be loaded with shift register bits [1:0].
REQ-021 Registers SHALL update on the clock edge after the cycle in which the CHK strobe is sampled, with cfg_update=1 for exactly that one cycle.
REQ-022 A CHK mismatch, or any CMD outside 01..03 with a valid checksum, SHALL pulse frame_err for one cycle with the same timing as cfg_update and leave all config outputs unchanged.
REQ-023 In every case, CHK SHALL return the FSM to IDLE.
REQ-024 Timeout counter: cleared in IDLE and on every accepted byte; increments each cycle in CMD/DATA/CHK.
REQ-025 When the timeout counter reaches TIMEOUT_CYC-1 without a strobe, the FSM SHALL go to IDLE, pulse frame_err once, and discard the partial frame.
REQ-026 If a strobe coincides with the timeout count, the byte SHALL win: it is processed normally and there is no timeout.
REQ-027 cfg_update and frame_err SHALL never be high in the same cycle.
REQ-028 Config outputs SHALL hold their values indefinitely between valid frames.
REQ-029 The timeout counter width SHALL be $clog2(TIMEOUT_CYC) bits and SHALL not wrap.

Reset
REQ-030 On rst_n=0, asynchronously: FSM=IDLE, counters=0, accumulator/shift register=0, freq_word=0, phase_word=0, wave_sel=0, cfg_update=0, frame_err=0.
REQ-031 Reset asserted mid-frame SHALL discard the partial frame; after release, the next byte SHALL be evaluated in IDLE.

Verification
REQ-032 Frequency frame: bytes AA 01 12 34 56 78 09 -> freq_word=32'h12345678, a single cfg_update pulse, frame_err stays 0.
REQ-033 Phase then wave frames: AA 02 00 00 0A BC B4 -> phase_word=12'hABC; then AA 03 00 00 00 02 01 -> wave_sel=2; freq_word unchanged.
REQ-034 Bad checksum: AA 01 12 34 56 78 08 -> frame_err pulse, freq_word keeps its prior value, no cfg_update.
REQ-035 Timeout and simultaneous events: AA 01 12 then silence for TIMEOUT_CYC cycles -> one frame_err, FSM in IDLE; a following full valid frame is accepted; a strobe exactly at count TIMEOUT_CYC-1 is accepted without error.
REQ-036 Garbage and reset: 55 00 AA 01 00 00 00 05 04 -> leading bytes ignored, freq_word=5; assert rst_n low after AA 01 00, release, then send full frame -> outputs at reset values until that frame completes, then updated correctly.

Source files
------------

// File: rtl/dds_cmd_ctrl.sv
// UART command decoder for a DDS core: parses HDR/CMD/4xDATA/CHK frames and
// loads the frequency, phase and waveform configuration registers.
module dds_cmd_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 100000,
  parameter logic [7:0]  HDR         = 8'hAA
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_dong_sig,
  output logic [31:0] freq_word,
  output logic [11:0] phase_word,
  output logic [1:0]  wave_sel,
  output logic        cfg_update,
  output logic        frame_err
);

  localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, CMD, DATA, CHK} state_e;

  state_e        state_q;
  logic [7:0]    cmd_q;
  logic [7:0]    acc_q;
  logic [31:0]   shift_q;
  logic [1:0]    cnt_q;
  logic [CW-1:0] tmo_q;
  logic [31:0]   freq_q;
  logic [11:0]   phase_q;
  logic [1:0]    wave_q;
  logic          cfg_update_q;
  logic          frame_err_q;

  logic [31:0]   shift_d;
  logic [7:0]    acc_d;

  always_comb begin
    shift_d = {shift_q[23:0], rx_data};
    acc_d   = acc_q ^ rx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cmd_q        <= '0;
      acc_q        <= '0;
      shift_q      <= '0;
      cnt_q        <= '0;
      tmo_q        <= '0;
      freq_q       <= '0;
      phase_q      <= '0;
      wave_q       <= '0;
      cfg_update_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      cfg_update_q <= 1'b0;
      frame_err_q  <= 1'b0;

      // A byte arriving on the last count wins over the timeout.
      if (state_q == IDLE || rx_dong_sig) begin
        tmo_q <= '0;
      end else if (tmo_q == TMO_LAST) begin
        tmo_q       <= '0;
        state_q     <= IDLE;
        frame_err_q <= 1'b1;
      end else begin
        tmo_q <= tmo_q + 1'b1;
      end

      if (rx_dong_sig) begin
        case (state_q)
          IDLE: begin
            if (rx_data == HDR) state_q <= CMD;
          end
          CMD: begin
            cmd_q   <= rx_data;
            acc_q   <= rx_data;
            cnt_q   <= '0;
            state_q <= DATA;
          end
          DATA: begin
            shift_q <= shift_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) state_q <= CHK;
          end
          CHK: begin
            state_q <= IDLE;
            if (rx_data != acc_q) begin
              frame_err_q <= 1'b1;
            end else begin
              case (cmd_q)
                8'h01: begin
                  freq_q       <= shift_q;
                  cfg_update_q <= 1'b1;
                end
                8'h02: begin
                  phase_q      <= shift_q[11:0];
                  cfg_update_q <= 1'b1;
                end
                8'h03: begin
                  wave_q       <= shift_q[1:0];
                  cfg_update_q <= 1'b1;
                end
                default: frame_err_q <= 1'b1;
              endcase
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign freq_word  = freq_q;
  assign phase_word = phase_q;
  assign wave_sel   = wave_q;
  assign cfg_update = cfg_update_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_dds_cmd_ctrl.sv
// Self-checking bench for dds_cmd_ctrl: directed frames plus randomised frames,
// compared every cycle against a frame-level reference model.
module tb_dds_cmd_ctrl;

  localparam int unsigned T   = 20;
  localparam logic [7:0]  HDR = 8'hAA;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_dong_sig;
  logic [31:0] freq_word;
  logic [11:0] phase_word;
  logic [1:0]  wave_sel;
  logic        cfg_update;
  logic        frame_err;

  dds_cmd_ctrl #(.TIMEOUT_CYC(T), .HDR(HDR)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_dong_sig (rx_dong_sig),
    .freq_word   (freq_word),
    .phase_word  (phase_word),
    .wave_sel    (wave_sel),
    .cfg_update  (cfg_update),
    .frame_err   (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passCount  = 0;
  int failCount  = 0;
  int totalCount = 0;
  int cfgSeen    = 0;
  int errSeen    = 0;

  // Reference model: bytes of the frame in progress and silence since the last byte
  logic [7:0]  frameQ[$];
  int          idleCnt;
  logic [31:0] mFreq;
  logic [11:0] mPhase;
  logic [1:0]  mWave;
  logic        expCfg;
  logic        expErr;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    frameQ.delete();
    idleCnt = 0;
    mFreq   = '0;
    mPhase  = '0;
    mWave   = '0;
  endtask

  task automatic modelFrame();
    logic [7:0]  chk;
    logic [31:0] payload;
    chk     = frameQ[1] ^ frameQ[2] ^ frameQ[3] ^ frameQ[4] ^ frameQ[5];
    payload = {frameQ[2], frameQ[3], frameQ[4], frameQ[5]};
    if (frameQ[6] == chk && frameQ[1] inside {8'h01, 8'h02, 8'h03}) begin
      expCfg = 1'b1;
      if (frameQ[1] == 8'h01) mFreq = payload;
      else if (frameQ[1] == 8'h02) mPhase = payload[11:0];
      else mWave = payload[1:0];
    end else begin
      expErr = 1'b1;
    end
    frameQ.delete();
  endtask

  // One clock cycle: drive, advance, update the model, compare all outputs
  task automatic applyStimulus(input logic strobe, input logic [7:0] data);
    rx_dong_sig = strobe;
    rx_data     = data;
    @(posedge clk);
    #1;
    rx_dong_sig = 1'b0;
    rx_data     = 8'($urandom);
    expCfg = 1'b0;
    expErr = 1'b0;
    if (strobe) begin
      idleCnt = 0;
      if (frameQ.size() == 0) begin
        if (data == HDR) frameQ.push_back(data);
      end else begin
        frameQ.push_back(data);
        if (frameQ.size() == 7) modelFrame();
      end
    end else if (frameQ.size() != 0) begin
      idleCnt++;
      if (idleCnt == int'(T)) begin
        expErr = 1'b1;
        frameQ.delete();
        idleCnt = 0;
      end
    end
    if (cfg_update) cfgSeen++;
    if (frame_err) errSeen++;
    checkOutput("cfg_update", 32'(cfg_update), 32'(expCfg));
    checkOutput("frame_err", 32'(frame_err), 32'(expErr));
    checkOutput("freq_word", freq_word, mFreq);
    checkOutput("phase_word", 32'(phase_word), 32'(mPhase));
    checkOutput("wave_sel", 32'(wave_sel), 32'(mWave));
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap);
    int g;
    g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
    repeat (g) applyStimulus(1'b0, 8'($urandom));
    applyStimulus(1'b1, b);
  endtask

  task automatic sendFrame(input logic [7:0] cmd, input logic [31:0] d,
                           input logic [7:0] chkFlip, input int gap);
    logic [7:0] chk;
    chk = cmd ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0] ^ chkFlip;
    sendByte(HDR, gap);
    sendByte(cmd, gap);
    sendByte(d[31:24], gap);
    sendByte(d[23:16], gap);
    sendByte(d[15:8], gap);
    sendByte(d[7:0], gap);
    sendByte(chk, gap);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_freq"}, freq_word, 32'h0);
    checkOutput({tag, "_phase"}, 32'(phase_word), 32'h0);
    checkOutput({tag, "_wave"}, 32'(wave_sel), 32'h0);
    checkOutput({tag, "_cfg"}, 32'(cfg_update), 32'h0);
    checkOutput({tag, "_err"}, 32'(frame_err), 32'h0);
  endtask

  initial begin
    int c0, e0, gap;
    logic [7:0]  cmd, flip;
    logic [31:0] d;

    rst_n       = 1'b0;
    rx_dong_sig = 1'b0;
    rx_data     = 8'h00;
    modelReset();
    @(posedge clk);
    @(posedge clk);
    #1;
    checkResetOutputs("reset");
    rst_n = 1'b1;

    // Frequency frame
    c0 = cfgSeen; e0 = errSeen;
    sendFrame(8'h01, 32'h12345678, 8'h00, -1);
    checkOutput("f1_freq", freq_word, 32'h12345678);
    checkOutput("f1_cfg_pulses", 32'(cfgSeen - c0), 32'd1);
    checkOutput("f1_err_pulses", 32'(errSeen - e0), 32'd0);

    // Phase then wave frames
    sendFrame(8'h02, 32'h00000ABC, 8'h00, -1);
    checkOutput("phase_abc", 32'(phase_word), 32'hABC);
    sendFrame(8'h03, 32'h00000002, 8'h00, -1);
    checkOutput("wave_2", 32'(wave_sel), 32'd2);
    checkOutput("freq_kept", freq_word, 32'h12345678);

    // Bad checksum: 08 instead of 09
    c0 = cfgSeen; e0 = errSeen;
    sendFrame(8'h01, 32'h12345678, 8'h01, -1);
    checkOutput("badchk_err_pulses", 32'(errSeen - e0), 32'd1);
    checkOutput("badchk_cfg_pulses", 32'(cfgSeen - c0), 32'd0);

    // Unknown command with a valid checksum, then header bytes used as payload
    e0 = errSeen;
    sendFrame(8'h07, 32'h00000001, 8'h00, -1);
    checkOutput("badcmd_err_pulses", 32'(errSeen - e0), 32'd1);
    sendFrame(8'h01, 32'hAAAAAAAA, 8'h00, 0);
    checkOutput("hdr_payload_freq", freq_word, 32'hAAAAAAAA);

    // Timeout after AA 01 12, then a full frame is accepted
    e0 = errSeen;
    sendByte(HDR, 0);
    sendByte(8'h01, 0);
    sendByte(8'h12, 0);
    repeat (T) applyStimulus(1'b0, 8'($urandom));
    checkOutput("timeout_err_pulses", 32'(errSeen - e0), 32'd1);
    sendFrame(8'h01, 32'h00C0FFEE, 8'h00, -1);
    checkOutput("after_timeout_freq", freq_word, 32'h00C0FFEE);

    // Every byte arrives exactly on the last timeout count
    e0 = errSeen;
    sendFrame(8'h01, 32'hCAFEF00D, 8'h00, int'(T) - 1);
    checkOutput("edge_freq", freq_word, 32'hCAFEF00D);
    checkOutput("edge_err_pulses", 32'(errSeen - e0), 32'd0);

    // Leading garbage ignored
    sendByte(8'h55, 0);
    sendByte(8'h00, 0);
    sendFrame(8'h01, 32'h00000005, 8'h00, 0);
    checkOutput("garbage_freq", freq_word, 32'h5);

    // Reset in the middle of a frame
    sendByte(HDR, 0);
    sendByte(8'h01, 0);
    sendByte(8'h00, 0);
    #3 rst_n = 1'b0;
    #2;
    checkResetOutputs("midreset");
    modelReset();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    sendFrame(8'h01, 32'h00000005, 8'h00, -1);
    checkOutput("postreset_freq", freq_word, 32'h5);

    // Randomised frames with occasional bad checksums, odd commands and long gaps
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: cmd = 8'h01;
        1: cmd = 8'h02;
        2: cmd = 8'h03;
        3: cmd = 8'h01;
        default: cmd = 8'($urandom);
      endcase
      d    = $urandom;
      flip = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      gap  = ($urandom_range(0, 7) == 0) ? int'(T) - 1 + int'($urandom_range(0, 1)) : -1;
      if ($urandom_range(0, 3) == 0) sendByte(8'($urandom), -1);
      sendFrame(cmd, d, flip, gap);
    end
    repeat (T + 2) applyStimulus(1'b0, 8'($urandom));

    if (failCount != 0) $display("[TB] %0d comparisons did not match", failCount);
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
